// File: rtl/ft60x_rx_ctrl.sv
// Read-side master for the FT600/FT601 245-synchronous FIFO bus: drains host
// words from the FTDI chip and pushes them into a downstream FIFO.
module ft60x_rx_ctrl #(
  parameter int D_BIT     = 32,
  parameter int BE_BIT    = 4,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iRXF_N,
  input  logic [D_BIT-1:0]  iDATA,
  input  logic [BE_BIT-1:0] iBE,
  output logic              oOE_N,
  output logic              oRD_N,
  input  logic              iAFULL,
  input  logic              iFULL,
  output logic              oWR,
  output logic [D_BIT-1:0]  oDATA,
  output logic [BE_BIT-1:0] oBE,
  output logic              oBUSY,
  output logic              oOVF,
  output logic [CNT_W-1:0]  oWORD_CNT,
  output logic [CNT_W-1:0]  oBYTE_CNT
);

  localparam bit LIMITED = (MAX_BURST != 0);
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = LIMITED ? BURST_W'(MAX_BURST - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OE,
    S_READ,
    S_END,
    S_TURN
  } state_t;

  state_t              state_reg, state_next;
  logic                oe_n_reg, oe_n_next;
  logic                rd_n_reg, rd_n_next;
  logic [BURST_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic                wr_reg, wr_next;
  logic [D_BIT-1:0]    data_reg, data_next;
  logic [BE_BIT-1:0]   be_reg, be_next;
  logic                ovf_reg, ovf_next;
  logic [CNT_W-1:0]    word_cnt_reg, word_cnt_next;
  logic [CNT_W-1:0]    byte_cnt_reg, byte_cnt_next;

  logic accept;
  logic burst_last;

  // The FTDI chip pops a word on every edge where our strobe is low and it
  // still has data, so that is exactly when a word must be taken.
  assign accept     = ~rd_n_reg & ~iRXF_N;
  assign burst_last = LIMITED && (burst_cnt_reg == BURST_LAST);

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    oe_n_next      = 1'b1;
    rd_n_next      = 1'b1;

    case (state_reg)
      S_IDLE: begin
        burst_cnt_next = '0;
        if (!iRXF_N && !iAFULL) begin
          state_next = S_OE;
        end
      end
      S_OE: begin
        state_next = S_READ;
      end
      S_READ: begin
        if (accept) begin
          burst_cnt_next = burst_cnt_reg + BURST_W'(1);
        end
        if (iRXF_N || iAFULL || (accept && burst_last)) begin
          state_next = S_END;
        end
      end
      S_END: begin
        state_next = S_TURN;
      end
      S_TURN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Pin strobes are registered straight from the next state so the FTDI
    // sees clean, glitch-free levels one cycle after each decision.
    case (state_next)
      S_OE: begin
        oe_n_next = 1'b0;
      end
      S_READ: begin
        oe_n_next = 1'b0;
        rd_n_next = 1'b0;
      end
      S_END: begin
        oe_n_next = 1'b0;
      end
      default: begin
        oe_n_next = 1'b1;
        rd_n_next = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_next       = 1'b0;
    data_next     = data_reg;
    be_next       = be_reg;
    ovf_next      = ovf_reg;
    word_cnt_next = word_cnt_reg;
    byte_cnt_next = byte_cnt_reg;

    // Words with no valid byte are consumed from the chip but never forwarded.
    if (accept && (iBE != '0)) begin
      wr_next   = 1'b1;
      data_next = iDATA;
      be_next   = iBE;
    end

    if (wr_reg) begin
      word_cnt_next = word_cnt_reg + CNT_W'(1);
      byte_cnt_next = byte_cnt_reg + CNT_W'($countones(be_reg));
      if (iFULL) begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_reg     <= S_IDLE;
      oe_n_reg      <= 1'b1;
      rd_n_reg      <= 1'b1;
      burst_cnt_reg <= '0;
      wr_reg        <= 1'b0;
      data_reg      <= '0;
      be_reg        <= '0;
      ovf_reg       <= 1'b0;
      word_cnt_reg  <= '0;
      byte_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      oe_n_reg      <= oe_n_next;
      rd_n_reg      <= rd_n_next;
      burst_cnt_reg <= burst_cnt_next;
      wr_reg        <= wr_next;
      data_reg      <= data_next;
      be_reg        <= be_next;
      ovf_reg       <= ovf_next;
      word_cnt_reg  <= word_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
    end
  end

  assign oOE_N     = oe_n_reg;
  assign oRD_N     = rd_n_reg;
  assign oWR       = wr_reg;
  assign oDATA     = data_reg;
  assign oBE       = be_reg;
  assign oBUSY     = (state_reg != S_IDLE);
  assign oOVF      = ovf_reg;
  assign oWORD_CNT = word_cnt_reg;
  assign oBYTE_CNT = byte_cnt_reg;

endmodule

// File: tb/tb_ft60x_rx_ctrl.sv
// Directed testbench for ft60x_rx_ctrl with a behavioural FTDI receive FIFO
// and a monitor recording downstream writes, burst lengths and idle gaps.
module tb_ft60x_rx_ctrl;

  localparam int D_BIT = 32;
  localparam int BE_BIT = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] BAD_WORD = 32'hA3A3_A3A3;

  logic              iCLK = 1'b0;
  logic              iRESET;
  logic              iRXF_N;
  logic [D_BIT-1:0]  iDATA;
  logic [BE_BIT-1:0] iBE;
  logic              oOE_N;
  logic              oRD_N;
  logic              iAFULL;
  logic              iFULL;
  logic              oWR;
  logic [D_BIT-1:0]  oDATA;
  logic [BE_BIT-1:0] oBE;
  logic              oBUSY;
  logic              oOVF;
  logic [CNT_W-1:0]  oWORD_CNT;
  logic [CNT_W-1:0]  oBYTE_CNT;

  int checks = 0;
  int errors = 0;

  // FTDI model: words 0..ftdi_n-1 queued, ftdi_idx is the head.
  logic [31:0] ftdi_data [0:1023];
  logic [3:0]  ftdi_be   [0:1023];
  int ftdi_n = 0;
  int ftdi_idx = 0;

  // Monitor records.
  logic [31:0] cap_data [$];
  logic [3:0]  cap_be   [$];
  int bursts [$];
  int gaps [$];
  int cur_burst = 0;
  int oe_run = 0;
  logic rd_prev = 1'b1;
  logic bad_seen = 1'b0;

  always #5 iCLK = ~iCLK;

  assign iRXF_N = !(ftdi_idx < ftdi_n);
  assign iDATA  = ftdi_data[ftdi_idx[9:0]];
  assign iBE    = ftdi_be[ftdi_idx[9:0]];

  always @(posedge iCLK) begin
    if (!oRD_N && !iRXF_N) ftdi_idx <= ftdi_idx + 1;
  end

  always @(negedge iCLK) begin
    if (oWR) begin
      cap_data.push_back(oDATA);
      cap_be.push_back(oBE);
    end
    if (oDATA == BAD_WORD) bad_seen <= 1'b1;
    if (!oRD_N && !iRXF_N) cur_burst <= cur_burst + 1;
    if (oRD_N && !rd_prev && cur_burst != 0) begin
      bursts.push_back(cur_burst);
      cur_burst <= 0;
    end
    rd_prev <= oRD_N;
    if (oOE_N) oe_run <= oe_run + 1;
    else begin
      if (oe_run != 0) gaps.push_back(oe_run);
      oe_run <= 0;
    end
  end

  ft60x_rx_ctrl #(
    .D_BIT(D_BIT), .BE_BIT(BE_BIT), .MAX_BURST(256), .CNT_W(CNT_W)
  ) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iRXF_N(iRXF_N), .iDATA(iDATA), .iBE(iBE),
    .oOE_N(oOE_N), .oRD_N(oRD_N), .iAFULL(iAFULL), .iFULL(iFULL), .oWR(oWR),
    .oDATA(oDATA), .oBE(oBE), .oBUSY(oBUSY), .oOVF(oOVF),
    .oWORD_CNT(oWORD_CNT), .oBYTE_CNT(oBYTE_CNT)
  );

  task automatic push_word(input logic [31:0] d, input logic [3:0] be);
    ftdi_data[ftdi_n] = d;
    ftdi_be[ftdi_n] = be;
    ftdi_n++;
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRESET = 1'b1;
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
  endtask

  // Waits until the controller is idle, the FTDI model empty and writes done.
  task automatic wait_idle(input string name);
    int stable = 0;
    int cyc = 0;
    while (stable < 3 && cyc < 2000) begin
      @(negedge iCLK);
      cyc++;
      if (!oBUSY && iRXF_N && !oWR) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 3) begin
      errors++;
      $display("FAIL %s idle_timeout: busy=%0b rxf_n=%0b, required idle within 2000 cycles", name, oBUSY, iRXF_N);
    end
  endtask

  task automatic test_reset();
    iRESET = 1'b1;
    iAFULL = 1'b0;
    iFULL = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({oOE_N, oRD_N, oWR, oBUSY, oOVF} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl: oe_n,rd_n,wr,busy,ovf=%b required 11000", {oOE_N, oRD_N, oWR, oBUSY, oOVF});
    end
    checks++;
    if (oDATA !== 32'h0 || oBE !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: data=%h be=%h required 0/0", oDATA, oBE);
    end
    checks++;
    if (oWORD_CNT !== 16'd0 || oBYTE_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: words=%0d bytes=%0d required 0/0", oWORD_CNT, oBYTE_CNT);
    end
    iRESET = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++;
    if (oBUSY !== 1'b0 || oOE_N !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b oe_n=%0b required 0/1", oBUSY, oOE_N);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int start = ftdi_n;
    int base = cap_data.size();
    int cyc = 0;
    push_word(32'h1111_1111, 4'hF);
    push_word(32'h2222_2222, 4'hF);
    push_word(32'h3333_3333, 4'hF);
    push_word(32'h4444_4444, 4'hF);
    while (oOE_N && cyc < 10) begin
      @(negedge iCLK);
      cyc++;
    end
    checks++;
    if (oOE_N !== 1'b0 || oRD_N !== 1'b1) begin
      errors++;
      $display("FAIL basic_oe_first: oe_n=%0b rd_n=%0b required 0/1", oOE_N, oRD_N);
    end
    @(negedge iCLK);
    checks++;
    if (oRD_N !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd_after_oe: rd_n=%0b required 0", oRD_N);
    end
    wait_idle("basic");
    checks++;
    if (cap_data.size() - base != 4) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d writes required 4", cap_data.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_data[base+i] !== ftdi_data[start+i] || cap_be[base+i] !== 4'hF) begin
          errors++;
          $display("FAIL basic_word%0d: data=%h be=%h required %h/f", i, cap_data[base+i], cap_be[base+i], ftdi_data[start+i]);
        end
      end
    end
    checks++;
    if (oWORD_CNT !== 16'd4 || oBYTE_CNT !== 16'd16) begin
      errors++;
      $display("FAIL basic_cnt: words=%0d bytes=%0d required 4/16", oWORD_CNT, oBYTE_CNT);
    end
    $display("test_basic done: %0d writes", cap_data.size() - base);
  endtask

  task automatic test_max_burst();
    int start = ftdi_n;
    int base = cap_data.size();
    int bbase = bursts.size();
    int gbase = gaps.size();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 600; i++) push_word(32'h1000_0000 + i, 4'hF);
    wait_idle("max_burst");
    checks++;
    if (bursts.size() - bbase != 3) begin
      errors++;
      $display("FAIL burst_count: got %0d bursts required 3", bursts.size() - bbase);
    end else begin
      checks++;
      if (bursts[bbase] != 256 || bursts[bbase+1] != 256 || bursts[bbase+2] != 88) begin
        errors++;
        $display("FAIL burst_sizes: got %0d,%0d,%0d required 256,256,88", bursts[bbase], bursts[bbase+1], bursts[bbase+2]);
      end
    end
    checks++;
    if (gaps.size() - gbase < 3) begin
      errors++;
      $display("FAIL burst_gaps_n: got %0d gaps required >=3", gaps.size() - gbase);
    end else if (gaps[gbase+1] != 2 || gaps[gbase+2] != 2) begin
      errors++;
      $display("FAIL burst_gap_len: got %0d,%0d idle cycles required 2,2", gaps[gbase+1], gaps[gbase+2]);
    end
    checks++;
    if (cap_data.size() - base != 600) begin
      errors++;
      $display("FAIL burst_writes: got %0d required 600", cap_data.size() - base);
    end else begin
      for (int i = 0; i < 600; i++) if (cap_data[base+i] !== ftdi_data[start+i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL burst_order: %0d words out of order required 0", bad);
      end
    end
    checks++;
    if (oWORD_CNT !== 16'd600 || oBYTE_CNT !== 16'd2400) begin
      errors++;
      $display("FAIL burst_cnt: words=%0d bytes=%0d required 600/2400", oWORD_CNT, oBYTE_CNT);
    end
    $display("test_max_burst done: %0d writes", cap_data.size() - base);
  endtask

  task automatic test_afull();
    int start = ftdi_n;
    int base = cap_data.size();
    int bbase = bursts.size();
    int cyc = 0;
    int bad = 0;
    for (int i = 0; i < 20; i++) push_word(32'h2000_0000 + i, 4'hF);
    while (ftdi_idx - start < 10 && cyc < 50) begin
      @(negedge iCLK);
      cyc++;
    end
    iAFULL = 1'b1;
    @(negedge iCLK);
    checks++;
    if (ftdi_idx - start != 11 || oRD_N !== 1'b1) begin
      errors++;
      $display("FAIL afull_stop: popped=%0d rd_n=%0b required 11/1", ftdi_idx - start, oRD_N);
    end
    repeat (6) @(negedge iCLK);
    checks++;
    if (ftdi_idx - start != 11 || oOE_N !== 1'b1 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL afull_hold: popped=%0d oe_n=%0b busy=%0b required 11/1/0", ftdi_idx - start, oOE_N, oBUSY);
    end
    iAFULL = 1'b0;
    wait_idle("afull");
    checks++;
    if (cap_data.size() - base != 20) begin
      errors++;
      $display("FAIL afull_writes: got %0d required 20", cap_data.size() - base);
    end else begin
      for (int i = 0; i < 20; i++) if (cap_data[base+i] !== ftdi_data[start+i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL afull_order: %0d words wrong required 0", bad);
      end
    end
    checks++;
    if (bursts.size() - bbase != 2 || bursts[bbase] != 11) begin
      errors++;
      $display("FAIL afull_bursts: got %0d bursts first=%0d required 2 bursts first=11", bursts.size() - bbase, bursts[bbase]);
    end
    $display("test_afull done: %0d writes", cap_data.size() - base);
  endtask

  task automatic test_byte_enable();
    int base = cap_data.size();
    do_reset();
    push_word(32'h0000_00B1, 4'h1);
    push_word(32'h0000_B2B2, 4'h3);
    push_word(BAD_WORD, 4'h0);
    push_word(32'hB4B4_B4B4, 4'hF);
    wait_idle("byte_enable");
    checks++;
    if (cap_data.size() - base != 3) begin
      errors++;
      $display("FAIL be_writes: got %0d required 3", cap_data.size() - base);
    end else begin
      checks++;
      if (cap_data[base] !== 32'h0000_00B1 || cap_be[base] !== 4'h1 ||
          cap_data[base+1] !== 32'h0000_B2B2 || cap_be[base+1] !== 4'h3 ||
          cap_data[base+2] !== 32'hB4B4_B4B4 || cap_be[base+2] !== 4'hF) begin
        errors++;
        $display("FAIL be_words: got %h/%h %h/%h %h/%h required 000000b1/1 0000b2b2/3 b4b4b4b4/f",
                 cap_data[base], cap_be[base], cap_data[base+1], cap_be[base+1], cap_data[base+2], cap_be[base+2]);
      end
    end
    checks++;
    if (oWORD_CNT !== 16'd3 || oBYTE_CNT !== 16'd7) begin
      errors++;
      $display("FAIL be_cnt: words=%0d bytes=%0d required 3/7", oWORD_CNT, oBYTE_CNT);
    end
    checks++;
    if (bad_seen !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_leak: BE=0 word seen on oDATA=%0b required 0", bad_seen);
    end
    $display("test_byte_enable done: %0d writes", cap_data.size() - base);
  endtask

  task automatic test_overflow();
    do_reset();
    checks++;
    if (oOVF !== 1'b0) begin
      errors++;
      $display("FAIL ovf_init: ovf=%0b required 0", oOVF);
    end
    iFULL = 1'b1;
    push_word(32'h5555_0001, 4'hF);
    push_word(32'h5555_0002, 4'hF);
    wait_idle("overflow");
    iFULL = 1'b0;
    repeat (5) @(negedge iCLK);
    checks++;
    if (oOVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%0b required 1", oOVF);
    end
    checks++;
    if (oWORD_CNT !== 16'd2 || oBYTE_CNT !== 16'd8) begin
      errors++;
      $display("FAIL ovf_cnt: words=%0d bytes=%0d required 2/8", oWORD_CNT, oBYTE_CNT);
    end
    do_reset();
    checks++;
    if (oOVF !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%0b required 0", oOVF);
    end
    $display("test_overflow done");
  endtask

  task automatic test_async_reset();
    int start = ftdi_n;
    int cyc = 0;
    int idx_rel;
    int base;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 50; i++) push_word(32'h3000_0000 + i, 4'hF);
    while ((oRD_N || ftdi_idx - start < 5) && cyc < 50) begin
      @(negedge iCLK);
      cyc++;
    end
    @(posedge iCLK);
    #2 iRESET = 1'b1;
    #1;
    checks++;
    if (oOE_N !== 1'b1 || oRD_N !== 1'b1 || oWR !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL async_release: oe_n=%0b rd_n=%0b wr=%0b busy=%0b required 1/1/0/0", oOE_N, oRD_N, oWR, oBUSY);
    end
    checks++;
    if (oWORD_CNT !== 16'd0 || oBYTE_CNT !== 16'd0) begin
      errors++;
      $display("FAIL async_cnt: words=%0d bytes=%0d required 0/0", oWORD_CNT, oBYTE_CNT);
    end
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    idx_rel = ftdi_idx;
    base = cap_data.size();
    cyc = 0;
    while (oOE_N && cyc < 10) begin
      @(negedge iCLK);
      cyc++;
    end
    checks++;
    if (oOE_N !== 1'b0 || oRD_N !== 1'b1) begin
      errors++;
      $display("FAIL async_restart_oe: oe_n=%0b rd_n=%0b required 0/1", oOE_N, oRD_N);
    end
    wait_idle("async_reset");
    checks++;
    if (cap_data.size() - base != start + 50 - idx_rel) begin
      errors++;
      $display("FAIL async_writes: got %0d required %0d", cap_data.size() - base, start + 50 - idx_rel);
    end else begin
      for (int i = 0; i < start + 50 - idx_rel; i++) if (cap_data[base+i] !== ftdi_data[idx_rel+i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL async_order: %0d words wrong required 0", bad);
      end
    end
    $display("test_async_reset done: %0d writes after restart", cap_data.size() - base);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_burst();
    test_afull();
    test_byte_enable();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft60x_rx_ctrl.md
Name: ft60x_rx_ctrl

Overview:
- Read-side master for the FT600/FT601 245-synchronous FIFO bus.
- Drains words the host has written into the FTDI chip and pushes them into a downstream write-only FIFO.
- Sits inside the top level between the FTDI pins (USB clock domain) and the data path.
- Outputs go directly to the oOE_N/oRD_N pins; the data/BE bus is tristated by the top level while oOE_N is low.

Parameters:
- D_BIT, 32, data bus width (32 for FT601, 16 for FT600).
- BE_BIT, 4, byte-enable width (D_BIT/8).
- MAX_BURST, 256, maximum words per read burst; 0 means unlimited.
- CNT_W, 16, width of the statistics counters.

Ports:
- iCLK  in  1  FTDI USB clock (100 or 66 MHz); the only clock.
- iRESET  in  1  asynchronous, active-high reset.
- iRXF_N  in  1  FTDI receive FIFO not empty, active low.
- iDATA  in  D_BIT  FTDI data bus (input half of ioDATA).
- iBE  in  BE_BIT  FTDI byte enables (input half of ioBE).
- oOE_N  out  1  FTDI output enable, active low, registered.
- oRD_N  out  1  FTDI read strobe, active low, registered.
- iAFULL  in  1  downstream FIFO almost full (free words <= 2).
- iFULL  in  1  downstream FIFO full.
- oWR  out  1  downstream write strobe, one word per cycle.
- oDATA  out  D_BIT  downstream write data.
- oBE  out  BE_BIT  downstream byte enables.
- oBUSY  out  1  high in every state except IDLE.
- oOVF  out  1  sticky overflow error.
- oWORD_CNT  out  CNT_W  words pushed.
- oBYTE_CNT  out  CNT_W  bytes pushed.

Behaviour:
- Reset (asynchronous, immediate):
  - oOE_N=1, oRD_N=1, oWR=0, oDATA=0, oBE=0, oOVF=0, both counters 0.
  - State returns to IDLE; the burst counter clears.
  - Reset mid-burst releases the bus at once; a partially captured word is discarded.
- FSM states: IDLE, OE, READ, END, TURN. Outputs are registered from the next state.
  - IDLE (OE_N=1, RD_N=1): go to OE when iRXF_N=0 and iAFULL=0.
  - OE (OE_N=0, RD_N=1): exactly one cycle for bus turnaround, then READ unconditionally.
  - READ (OE_N=0, RD_N=0): go to END at the edge where any of these holds: iRXF_N=1, iAFULL=1, or burst count reaches MAX_BURST-1 while a word is accepted.
  - END (OE_N=0, RD_N=1): one cycle, then TURN.
  - TURN (OE_N=1, RD_N=1): one cycle, then IDLE. Minimum gap between bursts is therefore 2 idle cycles.
- Capture rule:
  - A word is accepted on a rising edge where oRD_N=0 and iRXF_N=0. This includes the edge on which READ exits because of iAFULL or MAX_BURST.
  - An accepted word with iBE≠0 is registered: oDATA/oBE update and oWR=1 the next cycle. Latency is 1 clock from the sampling edge.
  - An accepted word with iBE=0 is dropped: no oWR, no count, but it does count toward MAX_BURST.
  - Edges with iRXF_N=1 capture nothing.
- Counters:
  - oWORD_CNT increments by 1 per oWR.
  - oBYTE_CNT increments by popcount(oBE) per oWR.
  - Both wrap modulo 2^CNT_W with no saturation.
- Overflow: if oWR=1 while iFULL=1, set oOVF (sticky until reset). The word is still presented and is counted.
- Simultaneous events:
  - iRXF_N rising together with iAFULL: single transition to END.
  - iAFULL in IDLE blocks burst start even when iRXF_N=0.
- With MAX_BURST=0 the burst ends only on iRXF_N or iAFULL.

Test Plan:
- FTDI holds 4 words 0x11111111..0x44444444, BE=4'hF, iAFULL=0 → oOE_N low 1 cycle before oRD_N; oWR pulses 4 times, data in order; oWORD_CNT=4, oBYTE_CNT=16; 2 idle cycles after oOE_N returns high.
- 600 words queued, MAX_BURST=256 → bursts of 256, 256, 88; each separated by END+TURN; final oWORD_CNT=600.
- iAFULL raised mid-burst after word 10 is sampled → exactly 1 more word is accepted on that edge; oRD_N high next cycle; reading resumes only after iAFULL=0; no word lost or duplicated.
- Words with BE 4'h1, 4'h3, 4'h0, 4'hF → 3 oWR pulses; oBYTE_CNT=7; the BE=0 word never appears on oDATA.
- iFULL=1 while words arrive → oOVF=1 and stays set; it clears only on iRESET.
- iRESET pulsed asynchronously during READ → oOE_N and oRD_N go high within the pulse (no clock edge needed); counters are 0; after release, a new burst starts with OE.
